// File: rtl/seven_seg_if.sv
// seven_seg_if: bundle between the display data path and the digit scanner.
//   master modport: data path side (drives nums/blank/dp_in/hex_mode,
//                   observes the pin-level outputs).
//   slave modport : scanner side (samples the data, drives digit/display/dp).
// Signals:
//   nums[4*DIGITS] : nibble i is the value of digit i (digit 0 rightmost)
//   blank[DIGITS]  : 1 forces digit i dark
//   dp_in[DIGITS]  : 1 lights the decimal point of digit i
//   hex_mode       : 1 hex glyphs, 0 decimal (10..15 dark)
//   digit[DIGITS]  : anode enables, active-low
//   display[7]     : segments {g,f,e,d,c,b,a}, active-low
//   dp             : decimal point, active-low
interface seven_seg_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] nums;
   logic [DIGITS-1:0]   blank;
   logic [DIGITS-1:0]   dp_in;
   logic                hex_mode;
   logic [DIGITS-1:0]   digit;
   logic [6:0]          display;
   logic                dp;

   modport master (
      output nums, blank, dp_in, hex_mode,
      input  digit, display, dp
   );

   modport slave (
      input  nums, blank, dp_in, hex_mode,
      output digit, display, dp
   );
endinterface

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for DIGITS common-anode
// seven-segment digits.
// Parameters:
//   DIGITS        : digits scanned (2..8); must match the interface parameter
//   SCAN_DIV_BITS : prescaler width, one digit slot = 2^SCAN_DIV_BITS clocks
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset (all digits dark, scan restarts)
//   bus : seven_seg_if.slave (data in, anode/segment/dp outputs)
// Optional feature:
//   SEVSEG_LZ_BLANK_EN defined -> leading-zero suppression on digits > 0.
// Anode, segments and dp are all registered on the same tick from the same
// next index, so the visible pattern can never skew against its anode.
module seven_seg_scan #(
   parameter int DIGITS        = 4,
   parameter int SCAN_DIV_BITS = 16
) (
   input  logic       clk,
   input  logic       rst,
   seven_seg_if.slave bus
);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [SCAN_DIV_BITS-1:0] div_reg;
   logic [IDX_W-1:0]         idx_reg;
   logic [DIGITS-1:0]        digit_reg;
   logic [6:0]               display_reg;
   logic                     dp_reg;

   logic                     tick;
   logic [IDX_W-1:0]         nidx;
   logic [3:0]               nibble;
   logic [DIGITS-1:0]        digit_next;
   logic [6:0]               display_next;
   logic                     dp_next;

   function automatic logic [6:0] glyph(input logic [3:0] n, input logic hex);
      logic [6:0] g;
      case (n)
         4'h0: g = 7'b1000000;
         4'h1: g = 7'b1111001;
         4'h2: g = 7'b0100100;
         4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001;
         4'h5: g = 7'b0010010;
         4'h6: g = 7'b0000010;
         4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0010000;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110;
         4'hD: g = 7'b0100001;
         4'hE: g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      // Decimal mode has no glyph for 10..15: render dark.
      if (!hex && (n > 4'd9)) begin
         g = 7'b1111111;
      end
      return g;
   endfunction

   assign tick = &div_reg;

   // Explicit wrap so non-power-of-two digit counts never visit unused slots.
   assign nidx = (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);

`ifdef SEVSEG_LZ_BLANK_EN
   // upper_zero[i]: nibble i and every higher nibble are zero.
   logic [DIGITS:1]   upper_zero;
   logic [DIGITS-1:0] lz_dark;

   assign upper_zero[DIGITS] = 1'b1;
   assign lz_dark[0]         = 1'b0;   // the units digit always shows

   for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lz
      assign upper_zero[gi] = upper_zero[gi+1] && (bus.nums[4*gi +: 4] == 4'h0);
      assign lz_dark[gi]    = upper_zero[gi];
   end
`endif

   always_comb begin
      nibble       = bus.nums[4*int'(nidx) +: 4];
      digit_next   = ~(DIGITS'(1) << nidx);
      display_next = glyph(nibble, bus.hex_mode);
      dp_next      = ~bus.dp_in[nidx];
`ifdef SEVSEG_LZ_BLANK_EN
      // A suppressed zero keeps its decimal point.
      if (lz_dark[nidx]) begin
         display_next = 7'b1111111;
      end
`endif
      // Blanking darkens segments and dp but keeps the anode driven so every
      // digit gets the same duty cycle.
      if (bus.blank[nidx]) begin
         display_next = 7'b1111111;
         dp_next      = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_reg     <= '0;
         idx_reg     <= IDX_W'(DIGITS - 1);
         digit_reg   <= '1;
         display_reg <= 7'b1111111;
         dp_reg      <= 1'b1;
      end else begin
         div_reg <= div_reg + SCAN_DIV_BITS'(1);
         if (tick) begin
            idx_reg     <= nidx;
            digit_reg   <= digit_next;
            display_reg <= display_next;
            dp_reg      <= dp_next;
         end
      end
   end

   assign bus.digit   = digit_reg;
   assign bus.display = display_reg;
   assign bus.dp      = dp_reg;

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed table-driven bench for seven_seg_scan with
// DIGITS=4, SCAN_DIV_BITS=2 (one tick every 4 clocks). Expected glyphs are
// hand-written per vector; the SEVSEG_LZ_BLANK_EN build selects the
// suppressed expectations.
module tb_seven_seg_scan;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   seven_seg_if #(.DIGITS(4)) bus ();

   seven_seg_scan #(.DIGITS(4), .SCAN_DIV_BITS(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   localparam logic [6:0] DARK = 7'b1111111;

   typedef struct {
      string       name;
      logic [15:0] nums;
      logic [3:0]  blank;
      logic [3:0]  dp_in;
      logic        hex;
      logic [27:0] seg;     // {digit3, digit2, digit1, digit0} expected display
      logic [3:0]  dp_exp;  // expected dp per digit (active-low)
   } vec_t;

   vec_t vecs [7];
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic check_dark(input string tag);
      check({tag, " digit"},   16'(bus.digit),   16'h000F);
      check({tag, " display"}, 16'(bus.display), 16'(DARK));
      check({tag, " dp"},      16'(bus.dp),      16'h0001);
   endtask

   task automatic run_vector(input vec_t v);
      int d;
      @(negedge clk);
      rst          = 1'b1;
      bus.nums     = v.nums;
      bus.blank    = v.blank;
      bus.dp_in    = v.dp_in;
      bus.hex_mode = v.hex;
      #1;
      check_dark({v.name, " in reset"});
      @(negedge clk);
      rst = 1'b0;
      // Two full refreshes: slot order 0,1,2,3 and the same again.
      for (int s = 0; s < 8; s++) begin
         d = s % 4;
         repeat (3) @(posedge clk);
         #1;
         if (s == 0) check_dark({v.name, " before first tick"});
         @(posedge clk);
         #1;
         check($sformatf("%s slot%0d digit", v.name, s),   16'(bus.digit),   16'(4'b1111 ^ (4'b0001 << d)));
         check($sformatf("%s slot%0d display", v.name, s), 16'(bus.display), 16'(v.seg[7*d +: 7]));
         check($sformatf("%s slot%0d dp", v.name, s),      16'(bus.dp),      16'(v.dp_exp[d]));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.nums     = 16'h0000;
      bus.blank    = 4'h0;
      bus.dp_in    = 4'h0;
      bus.hex_mode = 1'b0;

      vecs[0] = '{"dec_1234", 16'h1234, 4'b0000, 4'b0000, 1'b0,
                  {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111};
      vecs[1] = '{"hex_ABCD", 16'hABCD, 4'b0000, 4'b0000, 1'b1,
                  {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}, 4'b1111};
      vecs[2] = '{"dec_ABCD", 16'hABCD, 4'b0000, 4'b0000, 1'b0,
                  {DARK, DARK, DARK, DARK}, 4'b1111};
      vecs[3] = '{"blank_5678", 16'h5678, 4'b0100, 4'b0010, 1'b0,
                  {7'b0010010, DARK, 7'b1111000, 7'b0000000}, 4'b1101};
      vecs[5] = '{"hex_9EF0_dp", 16'h9EF0, 4'b0000, 4'b1111, 1'b1,
                  {7'b0010000, 7'b0000110, 7'b0001110, 7'b1000000}, 4'b0000};
`ifdef SEVSEG_LZ_BLANK_EN
      vecs[4] = '{"lz_0070", 16'h0070, 4'b0000, 4'b0000, 1'b0,
                  {DARK, DARK, 7'b1111000, 7'b1000000}, 4'b1111};
      vecs[6] = '{"lz_0000_dp3", 16'h0000, 4'b0000, 4'b1000, 1'b1,
                  {DARK, DARK, DARK, 7'b1000000}, 4'b0111};
`else
      vecs[4] = '{"zeros_0070", 16'h0070, 4'b0000, 4'b0000, 1'b0,
                  {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000}, 4'b1111};
      vecs[6] = '{"zeros_0000_dp3", 16'h0000, 4'b0000, 4'b1000, 1'b1,
                  {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b0111};
`endif

      repeat (2) @(posedge clk);

      for (int i = 0; i < 7; i++) begin
         run_vector(vecs[i]);
      end

      // Mid-slot reset while digit 2 is lit.
      @(negedge clk);
      rst          = 1'b1;
      bus.nums     = 16'h1234;
      bus.blank    = 4'h0;
      bus.dp_in    = 4'h0;
      bus.hex_mode = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("midrst digit2 lit digit",   16'(bus.digit),   16'h000B);
      check("midrst digit2 lit display", 16'(bus.display), 16'(7'b0100100));
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_dark("midrst immediate");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_dark("midrst before tick");
      @(posedge clk);
      #1;
      check("midrst restart digit",   16'(bus.digit),   16'h000E);
      check("midrst restart display", 16'(bus.display), 16'(7'b0011001));

      // Input change mid-scan reaches digit 1 at its next slot.
      @(negedge clk);
      bus.nums = 16'h1254;
      repeat (3) @(posedge clk);
      #1;
      check("late change old digit0", 16'(bus.display), 16'(7'b0011001));
      @(posedge clk);
      #1;
      check("late change digit1 digit",   16'(bus.digit),   16'h000D);
      check("late change digit1 display", 16'(bus.display), 16'(7'b0010010));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
